// File: rtl/vga_timing_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_if
// Purpose  : Bundles the VGA timing generator's enable input and all of its
//            video timing outputs.
//            master : the timing generator (drives sync/blank/pixel position)
//            slave  : the consumer (drives enable, observes everything else)
// Ports    : enable, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, pix_x[X_W],
//            pix_y[Y_W], line_start, frame_start, frame_cnt[8]
// Revision : 1.0 - initial release
// ============================================================================
interface vga_timing_if #(
    parameter int X_W = 10,
    parameter int Y_W = 9
);
    logic           enable;
    logic           VGA_CLK;
    logic           VGA_HS;
    logic           VGA_VS;
    logic           VGA_BLANK_N;
    logic [X_W-1:0] pix_x;
    logic [Y_W-1:0] pix_y;
    logic           line_start;
    logic           frame_start;
    logic [7:0]     frame_cnt;

    modport master (
        input  enable,
        output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N,
        output pix_x, pix_y, line_start, frame_start, frame_cnt
    );

    modport slave (
        output enable,
        input  VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N,
        input  pix_x, pix_y, line_start, frame_start, frame_cnt
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : VGA raster timing generator. Divides HCLK into a pixel clock,
//            runs horizontal/vertical counters and produces sync, blanking,
//            scaled pixel coordinates, line/frame pulses and a frame counter.
// Ports    : HCLK   - system clock (rising edge)
//            HRESET - synchronous active-high reset
//            bus    - vga_timing_if.master (enable in, timing outputs out)
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter int SCALE    = 1,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  wire logic       HCLK,
    input  wire logic       HRESET,
    vga_timing_if.master    bus
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_H_W     = $clog2(c_H_TOTAL);
    localparam int c_V_W     = $clog2(c_V_TOTAL);
    localparam int c_D_W     = $clog2(CLK_DIV);
    localparam int c_X_W     = $clog2(H_ACTIVE);
    localparam int c_Y_W     = $clog2(V_ACTIVE);
    localparam int c_SHIFT   = (SCALE == 4) ? 2 : ((SCALE == 2) ? 1 : 0);

    localparam logic [c_D_W-1:0] c_D_LAST   = c_D_W'(CLK_DIV - 1);
    localparam logic [c_D_W-1:0] c_D_HALF   = c_D_W'(CLK_DIV / 2);
    localparam logic [c_H_W-1:0] c_H_LAST   = c_H_W'(c_H_TOTAL - 1);
    localparam logic [c_V_W-1:0] c_V_LAST   = c_V_W'(c_V_TOTAL - 1);
    localparam logic [c_H_W-1:0] c_H_ACT    = c_H_W'(H_ACTIVE);
    localparam logic [c_V_W-1:0] c_V_ACT    = c_V_W'(V_ACTIVE);
    localparam logic [c_H_W-1:0] c_HS_FIRST = c_H_W'(H_ACTIVE + H_FP);
    localparam logic [c_H_W-1:0] c_HS_LAST  = c_H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [c_V_W-1:0] c_VS_FIRST = c_V_W'(V_ACTIVE + V_FP);
    localparam logic [c_V_W-1:0] c_VS_LAST  = c_V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [c_D_W-1:0] r_div;
    logic [c_H_W-1:0] r_h;
    logic [c_V_W-1:0] r_v;
    logic             r_vga_clk;
    logic             r_hs;
    logic             r_vs;
    logic             r_blank_n;
    logic [c_X_W-1:0] r_pix_x;
    logic [c_Y_W-1:0] r_pix_y;
    logic             r_line_start;
    logic             r_frame_start;
    logic [7:0]       r_frame_cnt;

    logic             w_tick;
    logic [c_D_W-1:0] w_div_nxt;
    logic [c_H_W-1:0] w_h_nxt;
    logic [c_V_W-1:0] w_v_nxt;
    logic             w_active;
    logic             w_hs;
    logic             w_vs;
    logic             w_line_start;
    logic             w_frame_start;

    // Next-state counter values. Every output register is loaded from these
    // so outputs and counters change on the same HCLK edge.
    always_comb begin
        w_tick    = bus.enable && (r_div == c_D_LAST);
        w_div_nxt = r_div;
        w_h_nxt   = r_h;
        w_v_nxt   = r_v;
        if (bus.enable) begin
            w_div_nxt = (r_div == c_D_LAST) ? '0 : r_div + 1'b1;
        end
        if (w_tick) begin
            if (r_h == c_H_LAST) begin
                w_h_nxt = '0;
                w_v_nxt = (r_v == c_V_LAST) ? '0 : r_v + 1'b1;
            end else begin
                w_h_nxt = r_h + 1'b1;
            end
        end
        w_active      = (w_h_nxt < c_H_ACT) && (w_v_nxt < c_V_ACT);
        w_hs          = ((w_h_nxt >= c_HS_FIRST) && (w_h_nxt <= c_HS_LAST)) ? HS_POL : ~HS_POL;
        w_vs          = ((w_v_nxt >= c_VS_FIRST) && (w_v_nxt <= c_VS_LAST)) ? VS_POL : ~VS_POL;
        w_line_start  = w_tick && (w_h_nxt == '0);
        w_frame_start = w_line_start && (w_v_nxt == '0);
    end

    // Counters reset to the last position of the frame so that the first
    // pixel tick after release lands on (0,0) and raises frame_start.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_div         <= '0;
            r_h           <= c_H_LAST;
            r_v           <= c_V_LAST;
            r_vga_clk     <= 1'b0;
            r_hs          <= ~HS_POL;
            r_vs          <= ~VS_POL;
            r_blank_n     <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= 8'd0;
        end else begin
            r_div         <= w_div_nxt;
            r_h           <= w_h_nxt;
            r_v           <= w_v_nxt;
            r_vga_clk     <= (w_div_nxt >= c_D_HALF);
            r_hs          <= w_hs;
            r_vs          <= w_vs;
            // Blanking is forced while paused; coordinates keep their value.
            r_blank_n     <= w_active && bus.enable;
            r_pix_x       <= w_active ? c_X_W'(w_h_nxt >> c_SHIFT) : '0;
            r_pix_y       <= w_active ? c_Y_W'(w_v_nxt >> c_SHIFT) : '0;
            r_line_start  <= w_line_start;
            r_frame_start <= w_frame_start;
            if (w_frame_start) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign bus.VGA_CLK     = r_vga_clk;
    assign bus.VGA_HS      = r_hs;
    assign bus.VGA_VS      = r_vs;
    assign bus.VGA_BLANK_N = r_blank_n;
    assign bus.pix_x       = r_pix_x;
    assign bus.pix_y       = r_pix_y;
    assign bus.line_start  = r_line_start;
    assign bus.frame_start = r_frame_start;
    assign bus.frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Directed self-checking bench. A small-geometry instance
//            (12x8 totals, SCALE=2, VS_POL=1) exercises scan order, pause,
//            mid-frame reset and frame counter wrap; a default-geometry
//            instance checks the standard 640x480 line timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    vga_timing_if #(.X_W(3), .Y_W(2)) s_if ();
    vga_timing_if                     d_if ();

    // Small geometry: H 8+1+2+1=12, V 4+1+2+1=8, frame = 96 pixels = 192 HCLK.
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(2), .SCALE(2), .HS_POL(1'b0), .VS_POL(1'b1)
    ) u_small (
        .HCLK   (clk),
        .HRESET (rst),
        .bus    (s_if)
    );

    vga_timing_gen u_dflt (
        .HCLK   (clk),
        .HRESET (rst),
        .bus    (d_if)
    );

    function automatic logic [10:0] s_vec();
        return {s_if.VGA_CLK, s_if.VGA_HS, s_if.VGA_VS, s_if.VGA_BLANK_N,
                s_if.pix_x, s_if.pix_y, s_if.line_start, s_if.frame_start};
    endfunction

    task automatic wait_s_fs(input int limit, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (s_if.frame_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_if.enable = 1'b1;
        d_if.enable = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (s_vec() !== 11'b01000000000) begin
            bad++; $display("FAIL reset_small_outputs got=%b exp=%b", s_vec(), 11'b01000000000);
        end
        total++;
        if (s_if.frame_cnt !== 8'd0) begin
            bad++; $display("FAIL reset_frame_cnt got=%0d exp=0", s_if.frame_cnt);
        end
        total++;
        if ({d_if.VGA_CLK, d_if.VGA_HS, d_if.VGA_VS, d_if.VGA_BLANK_N,
             d_if.line_start, d_if.frame_start} !== 6'b011000) begin
            bad++; $display("FAIL reset_dflt_outputs got=%b exp=011000",
                {d_if.VGA_CLK, d_if.VGA_HS, d_if.VGA_VS, d_if.VGA_BLANK_N,
                 d_if.line_start, d_if.frame_start});
        end
    endtask

    task automatic test_first_frame();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({s_if.frame_start, s_if.VGA_CLK, d_if.frame_start} !== 3'b010) begin
            bad++; $display("FAIL first_edge1 got=%b exp=010",
                {s_if.frame_start, s_if.VGA_CLK, d_if.frame_start});
        end
        @(negedge clk);
        total++;
        if ({s_if.frame_start, s_if.line_start, s_if.VGA_BLANK_N, d_if.frame_start} !== 4'b1111) begin
            bad++; $display("FAIL first_edge2_pulses got=%b exp=1111",
                {s_if.frame_start, s_if.line_start, s_if.VGA_BLANK_N, d_if.frame_start});
        end
        total++;
        if (s_if.frame_cnt !== 8'd1) begin
            bad++; $display("FAIL first_frame_cnt got=%0d exp=1", s_if.frame_cnt);
        end
    endtask

    // Called on the negedge right after the first frame_start (cycle 0).
    task automatic test_line_scan();
        int errs;
        errs = 0;
        for (int c = 0; c <= 192; c++) begin
            int p, h, v;
            bit act, tick;
            logic [10:0] exp;
            if (c != 0) @(negedge clk);
            p    = c / 2;
            h    = p % 12;
            v    = (p / 12) % 8;
            tick = (c % 2) == 0;
            act  = (h < 8) && (v < 4);
            exp[10]  = (c % 2) == 1;
            exp[9]   = !((h >= 9) && (h <= 10));
            exp[8]   = (v >= 5) && (v <= 6);
            exp[7]   = act;
            exp[6:4] = act ? 3'(h / 2) : 3'd0;
            exp[3:2] = act ? 2'(v / 2) : 2'd0;
            exp[1]   = tick && (h == 0);
            exp[0]   = tick && (h == 0) && (v == 0);
            total++;
            if (s_vec() !== exp) begin
                bad++; errs++;
                if (errs < 8) $display("FAIL scan cycle=%0d got=%b exp=%b", c, s_vec(), exp);
            end
        end
        total++;
        if (s_if.frame_cnt !== 8'd2) begin
            bad++; $display("FAIL scan_frame_cnt got=%0d exp=2", s_if.frame_cnt);
        end
    endtask

    task automatic test_default_line();
        bit ok;
        int blank_cnt, hs_cnt, hs_first, clk_cnt, extra_ls;
        ok = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (d_if.line_start) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) begin
            bad++; $display("FAIL dflt_line_start_timeout got=none exp=pulse");
        end else begin
            blank_cnt = 0; hs_cnt = 0; hs_first = -1; clk_cnt = 0; extra_ls = 0;
            for (int c = 0; c < 1600; c++) begin
                if (c != 0) @(negedge clk);
                if (d_if.VGA_BLANK_N) blank_cnt++;
                if (d_if.VGA_CLK) clk_cnt++;
                if (!d_if.VGA_HS) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = c;
                end
                if (c != 0 && d_if.line_start) extra_ls++;
            end
            @(negedge clk);
            total++;
            if (blank_cnt != 1280) begin
                bad++; $display("FAIL dflt_blank_len got=%0d exp=1280", blank_cnt);
            end
            total++;
            if (hs_first != 1312) begin
                bad++; $display("FAIL dflt_hs_start got=%0d exp=1312", hs_first);
            end
            total++;
            if (hs_cnt != 192) begin
                bad++; $display("FAIL dflt_hs_len got=%0d exp=192", hs_cnt);
            end
            total++;
            if (clk_cnt != 800) begin
                bad++; $display("FAIL dflt_vga_clk_duty got=%0d exp=800", clk_cnt);
            end
            total++;
            if (d_if.line_start !== 1'b1 || extra_ls != 0) begin
                bad++; $display("FAIL dflt_line_period got=%b/%0d exp=1/0", d_if.line_start, extra_ls);
            end
        end
    endtask

    task automatic test_enable_freeze();
        bit ok;
        wait_s_fs(400, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL freeze_wait_timeout got=none exp=frame_start");
            return;
        end
        repeat (10) @(negedge clk);     // h=5 just after its tick
        total++;
        if ({s_if.VGA_BLANK_N, s_if.pix_x} !== 4'b1010) begin
            bad++; $display("FAIL freeze_pre got=%b exp=1010", {s_if.VGA_BLANK_N, s_if.pix_x});
        end
        s_if.enable = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            total++;
            if (s_vec() !== 11'b01000100000) begin
                bad++; $display("FAIL freeze_hold k=%0d got=%b exp=%b", k, s_vec(), 11'b01000100000);
            end
        end
        s_if.enable = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            total++;
            if (s_if.line_start !== (k == 14)) begin
                bad++; $display("FAIL resume_line_start k=%0d got=%b exp=%b", k, s_if.line_start, (k == 14));
            end
            if (k == 1) begin
                total++;
                if ({s_if.VGA_CLK, s_if.VGA_BLANK_N, s_if.pix_x} !== 5'b11010) begin
                    bad++; $display("FAIL resume_first got=%b exp=11010",
                        {s_if.VGA_CLK, s_if.VGA_BLANK_N, s_if.pix_x});
                end
            end
            if (k == 2) begin
                total++;
                if (s_if.pix_x !== 3'd3) begin
                    bad++; $display("FAIL resume_next_pixel got=%0d exp=3", s_if.pix_x);
                end
            end
            if (k == 6) begin
                total++;
                if (s_if.VGA_BLANK_N !== 1'b0) begin
                    bad++; $display("FAIL resume_blank_h8 got=%b exp=0", s_if.VGA_BLANK_N);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        wait_s_fs(400, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL midreset_wait_timeout got=none exp=frame_start");
            return;
        end
        repeat (55) @(negedge clk);     // v=2, h=3
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({s_vec(), s_if.frame_cnt} !== {11'b01000000000, 8'd0}) begin
            bad++; $display("FAIL midreset_values got=%b/%0d exp=%b/0", s_vec(), s_if.frame_cnt, 11'b01000000000);
        end
        total++;
        if ({d_if.VGA_HS, d_if.VGA_BLANK_N, d_if.frame_cnt} !== {2'b10, 8'd0}) begin
            bad++; $display("FAIL midreset_dflt got=%b/%0d exp=10/0", {d_if.VGA_HS, d_if.VGA_BLANK_N}, d_if.frame_cnt);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (s_if.frame_start !== 1'b0 || s_if.line_start !== 1'b0) begin
                bad++; $display("FAIL midreset_pulse k=%0d got=%b exp=00", k, {s_if.frame_start, s_if.line_start});
            end
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (s_if.frame_start !== 1'b0) begin
            bad++; $display("FAIL midreset_rel1 got=%b exp=0", s_if.frame_start);
        end
        @(negedge clk);
        total++;
        if ({s_if.frame_start, s_if.frame_cnt} !== {1'b1, 8'd1}) begin
            bad++; $display("FAIL midreset_rel2 got=%b/%0d exp=1/1", s_if.frame_start, s_if.frame_cnt);
        end
    endtask

    // Starts on the negedge of the first frame_start after reset (frame_cnt=1).
    task automatic test_frame_wrap();
        bit ok;
        for (int i = 2; i <= 256; i++) begin
            wait_s_fs(250, ok);
            total++;
            if (!ok) begin
                bad++; $display("FAIL wrap_timeout frame=%0d got=none exp=frame_start", i);
                return;
            end
            total++;
            if (s_if.frame_cnt !== 8'(i)) begin
                bad++; $display("FAIL wrap_frame_cnt frame=%0d got=%0d exp=%0d", i, s_if.frame_cnt, 8'(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_line_scan();
        test_default_line();
        test_enable_freeze();
        test_reset_midframe();
        test_frame_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
